word_display_reader: RTL and testbench

- Read-side engine for the hangman word store.
- Walks the stored word in the dual-port RAM read port, addresses 1..length, one character per beat.
- Merges each character with a per-position revealed mask. Streams either the letter or a blank code to the on-screen character renderer over a valid/ready handshake.
- Owns the revealed mask. The guess/compare logic sets mask bits on matches.

---
 rtl/hangman_pkg.sv | 17 +
 rtl/reveal_mask.sv | 39 +++
 rtl/word_display_reader.sv | 142 ++++++++++++++
 tb/tb_word_display_reader.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hangman_pkg.sv
// Shared constants and types for the hangman word-store datapath.
package hangman_pkg;

    localparam int CHAR_W = 5;
    localparam int ADDR_W = 5;

    localparam logic [CHAR_W-1:0] BLANK_CODE_DEF = 5'd31;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        PRESENT,
        DONE
    } reader_state_t;

endpackage

// File: rtl/reveal_mask.sv
// Per-position revealed mask for the hangman word: clear-then-set update
// each cycle, combinational single-bit read by address.
module reveal_mask
    import hangman_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
    input  logic              set,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_bit
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] mask;
    logic [DEPTH-1:0] mask_next;

    // NOTE: combinational blocks use blocking '=' and assign a default first, so no latch is inferred.
    always_comb begin
        mask_next = clear ? '0 : mask;
        if (set && (set_addr != '0)) begin
            mask_next[set_addr] = 1'b1;
        end
    end

    // NOTE: this is a flop array, not a RAM, so it is reset; a new game relies on it starting empty.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mask <= '0;
        end else begin
            mask <= mask_next;
        end
    end

    assign rd_bit = mask[rd_addr];

endmodule

// File: rtl/word_display_reader.sv
// Read-side scan engine: walks word RAM addresses 1..length, merges each letter
// with the reveal mask and streams beats. Optional macro WORD_READER_REMAINING_EN.
module word_display_reader
    import hangman_pkg::*;
#(
    parameter int                RD_LAT     = 1,
    parameter logic [CHAR_W-1:0] BLANK_CODE = BLANK_CODE_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] length,
    output logic [ADDR_W-1:0] rdaddress,
    output logic              rden,
    input  logic [CHAR_W-1:0] q,
    input  logic              reveal_we,
    input  logic [ADDR_W-1:0] reveal_addr,
    input  logic              clear_reveal,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CHAR_W-1:0] out_char,
    output logic [ADDR_W-1:0] out_pos,
    output logic              out_blank,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] remaining
);

    reader_state_t     state;
    reader_state_t     state_next;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] len;
    logic [1:0]        lat_cnt;
    logic              mask_bit;
    logic              start_ok;
    logic              accept;
    logic              capture;

    assign start_ok = (state == IDLE) && start;
    assign accept   = (state == PRESENT) && out_ready;
    // The counter's final decrement (1 -> 0) is the cycle q becomes valid.
    assign capture  = (state == WAIT) && (lat_cnt == 2'd1);

    reveal_mask u_mask (
        .clk      (clk),
        .resetn   (resetn),
        .clear    (clear_reveal),
        .set      (reveal_we),
        .set_addr (reveal_addr),
        .rd_addr  (addr),
        .rd_bit   (mask_bit)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = (length != '0) ? ISSUE : DONE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (capture) state_next = PRESENT;
            PRESENT: if (out_ready) state_next = out_last ? DONE : ISSUE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr      <= '0;
            len       <= '0;
            lat_cnt   <= '0;
            out_char  <= '0;
            out_pos   <= '0;
            out_blank <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (start_ok && (length != '0)) begin
                addr <= ADDR_W'(1);
                len  <= length;
            end else if (accept && !out_last) begin
                addr <= addr + 1'b1;
            end

            if (state == ISSUE) begin
                lat_cnt <= 2'(RD_LAT);
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt - 1'b1;
            end

            if (capture) begin
                out_char  <= mask_bit ? q : BLANK_CODE;
                out_blank <= ~mask_bit;
                out_pos   <= addr;
                out_last  <= (addr == len);
            end
        end
    end

    assign rdaddress = addr;
    assign rden      = (state == ISSUE);
    assign out_valid = (state == PRESENT);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

`ifdef WORD_READER_REMAINING_EN
    logic [ADDR_W-1:0] blank_cnt;
    logic [ADDR_W-1:0] remaining_q;

    // The final beat's own blank is folded in so the value is ready on the done cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            blank_cnt   <= '0;
            remaining_q <= '0;
        end else begin
            if (start_ok) begin
                blank_cnt <= '0;
            end else if (accept && out_blank) begin
                blank_cnt <= blank_cnt + 1'b1;
            end

            if (start_ok && (length == '0)) begin
                remaining_q <= '0;
            end else if (accept && out_last) begin
                remaining_q <= blank_cnt + {{(ADDR_W-1){1'b0}}, out_blank};
            end
        end
    end

    assign remaining = remaining_q;
`else
    assign remaining = '0;
`endif

endmodule

// File: tb/tb_word_display_reader.sv
// Self-checking bench for word_display_reader: a behavioural model of the word,
// mask and expected beats, with random words, masks and backpressure.
module tb_word_display_reader;

    localparam int         RD_LAT = 1;
    localparam logic [4:0] BLANK  = 5'd31;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [4:0] length;
    logic [4:0] rdaddress;
    logic       rden;
    logic [4:0] q;
    logic       reveal_we;
    logic [4:0] reveal_addr;
    logic       clear_reveal;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_char;
    logic [4:0] out_pos;
    logic       out_blank;
    logic       out_last;
    logic       busy;
    logic       done;
    logic [4:0] remaining;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    word_display_reader #(.RD_LAT(RD_LAT), .BLANK_CODE(BLANK)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .length       (length),
        .rdaddress    (rdaddress),
        .rden         (rden),
        .q            (q),
        .reveal_we    (reveal_we),
        .reveal_addr  (reveal_addr),
        .clear_reveal (clear_reveal),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_char     (out_char),
        .out_pos      (out_pos),
        .out_blank    (out_blank),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done),
        .remaining    (remaining)
    );

    // Word RAM with RD_LAT cycles of read latency; data is unknown unless a read was issued.
    logic [4:0] mem [32];
    logic [4:0] q_pipe [RD_LAT];
    always @(posedge clk) begin
        q_pipe[0] <= rden ? mem[rdaddress] : 5'bx;
        for (int i = 1; i < RD_LAT; i++) q_pipe[i] <= q_pipe[i-1];
    end
    assign q = q_pipe[RD_LAT-1];

    logic [4:0] rd_addrs[$];
    int         done_total = 0;
    always @(posedge clk) begin
        if (rden) rd_addrs.push_back(rdaddress);
        if (done) done_total++;
    end

    // Reference model of the reveal mask.
    bit model_mask [32];

    typedef struct {
        logic [4:0] ch;
        logic [4:0] pos;
        logic       blank;
        logic       last;
        int         first_seen;
        int         seen_cycles;
    } beat_t;

    function automatic beat_t model_beat(input int p, input int len);
        beat_t b;
        b.pos         = 5'(p);
        b.blank       = !model_mask[p];
        b.ch          = model_mask[p] ? mem[p] : BLANK;
        b.last        = (p == len);
        b.first_seen  = 0;
        b.seen_cycles = 0;
        return b;
    endfunction

    function automatic logic [4:0] exp_remaining(input int len);
        int n = 0;
        for (int p = 1; p <= len; p++) if (!model_mask[p]) n++;
`ifdef WORD_READER_REMAINING_EN
        return 5'(n);
`else
        return (n < 0) ? 5'd1 : 5'd0;
`endif
    endfunction

    task automatic mask_op(input logic we, input logic [4:0] a, input logic clr);
        reveal_we    = we;
        reveal_addr  = a;
        clear_reveal = clr;
        @(negedge clk);
        reveal_we    = 1'b0;
        clear_reveal = 1'b0;
        if (clr) for (int i = 0; i < 32; i++) model_mask[i] = 1'b0;
        if (we && a != 5'd0) model_mask[a] = 1'b1;
    endtask

    // Results of the most recent scan.
    beat_t beats[$];
    int    unstable, done_seen, done_iter, busy_cycles, valid_cycles, addr_base;
    bit    timed_out;
    logic [4:0] rem_at_done;

    task automatic run_scan(input int len, input int ready_pct, input int stall_beat,
                            input int stall_len, input int poke_iter);
        beat_t cur;
        bit    pending = 0;
        beats.delete();
        unstable = 0; done_seen = 0; done_iter = -1; busy_cycles = 0; valid_cycles = 0;
        rem_at_done = 5'd0;
        addr_base = rd_addrs.size();
        start  = 1'b1;
        length = 5'(len);
        @(negedge clk);
        start  = 1'b0;
        length = 5'($urandom_range(31));
        for (int c = 0; c < 3000; c++) begin
            if (busy) busy_cycles++;
            if (done) begin
                done_seen++;
                if (done_iter < 0) begin
                    done_iter   = c;
                    rem_at_done = remaining;
                end
            end
            start = (c == poke_iter) && busy;
            if (out_valid) begin
                valid_cycles++;
                if (!pending) begin
                    pending = 1;
                    cur.ch = out_char; cur.pos = out_pos; cur.blank = out_blank; cur.last = out_last;
                    cur.first_seen = c; cur.seen_cycles = 0;
                end else if ({out_char, out_pos, out_blank, out_last} !==
                             {cur.ch, cur.pos, cur.blank, cur.last}) begin
                    unstable++;
                end
                cur.seen_cycles++;
                if (beats.size() == stall_beat && cur.seen_cycles <= stall_len) out_ready = 1'b0;
                else out_ready = ($urandom_range(99) < ready_pct);
                if (out_ready) begin
                    beats.push_back(cur);
                    pending = 0;
                end
            end else begin
                out_ready = 1'($urandom_range(1));
            end
            if (done_iter >= 0 && c >= done_iter + 2) break;
            @(negedge clk);
        end
        timed_out = (done_iter < 0);
        start     = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rdaddress, rden, out_valid, out_char, out_pos, out_blank, out_last, busy, done, remaining} !== '0)
            begin errors++; $display("FAIL reset_outputs: got %b want all zero",
                {rdaddress, rden, out_valid, out_char, out_pos, out_blank, out_last, busy, done, remaining}); end
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, out_valid, rden} !== 3'b000) begin
            errors++; $display("FAIL reset_idle: busy/valid/rden=%b want 000", {busy, out_valid, rden});
        end
    endtask

    task automatic test_basic();
        logic [4:0] want_ch [4] = '{5'd3, 5'd31, 5'd3, 5'd31};
        logic [4:0] word    [4] = '{5'd3, 5'd7, 5'd3, 5'd9};
        for (int p = 1; p <= 4; p++) mem[p] = word[p-1];
        mask_op(1'b0, 5'd0, 1'b1);
        mask_op(1'b1, 5'd1, 1'b0);
        mask_op(1'b1, 5'd3, 1'b0);
        run_scan(4, 100, -1, 0, -1);
        checks++;
        if (timed_out || beats.size() != 4) begin
            errors++; $display("FAIL basic_count: got %0d beats (timeout=%0d) want 4", beats.size(), timed_out);
        end
        for (int i = 0; i < beats.size() && i < 4; i++) begin
            checks++;
            if ({beats[i].ch, beats[i].blank, beats[i].pos, beats[i].last} !==
                {want_ch[i], (i % 2 == 1), 5'(i + 1), (i == 3)}) begin
                errors++; $display("FAIL basic_beat%0d: got ch=%0d blank=%0d pos=%0d last=%0d want ch=%0d blank=%0d pos=%0d last=%0d",
                    i + 1, beats[i].ch, beats[i].blank, beats[i].pos, beats[i].last, want_ch[i], i % 2, i + 1, i == 3);
            end
            if (i > 0) begin
                checks++;
                if (beats[i].first_seen - beats[i-1].first_seen != RD_LAT + 2) begin
                    errors++; $display("FAIL basic_spacing%0d: got %0d cycles want %0d", i + 1,
                        beats[i].first_seen - beats[i-1].first_seen, RD_LAT + 2);
                end
            end
        end
        checks++;
        if (beats.size() > 0 && beats[0].first_seen != RD_LAT + 1) begin
            errors++; $display("FAIL basic_latency: first beat at %0d want %0d", beats[0].first_seen, RD_LAT + 1);
        end
        checks++;
        if (beats.size() == 4 && (done_iter != beats[3].first_seen + 1 || done_seen != 1)) begin
            errors++; $display("FAIL basic_done: done at %0d (x%0d) want %0d (x1)", done_iter, done_seen,
                beats[3].first_seen + 1);
        end
        checks++;
        if (rd_addrs.size() - addr_base != 4) begin
            errors++; $display("FAIL basic_reads: got %0d reads want 4", rd_addrs.size() - addr_base);
        end
        checks++;
        if (rem_at_done !== exp_remaining(4)) begin
            errors++; $display("FAIL basic_remaining: got %0d want %0d", rem_at_done, exp_remaining(4));
        end
        mask_op(1'b1, 5'd2, 1'b0);
        mask_op(1'b1, 5'd4, 1'b0);
        run_scan(4, 100, -1, 0, -1);
        for (int i = 0; i < beats.size() && i < 4; i++) begin
            checks++;
            if ({beats[i].ch, beats[i].blank} !== {word[i], 1'b0}) begin
                errors++; $display("FAIL full_beat%0d: got ch=%0d blank=%0d want ch=%0d blank=0",
                    i + 1, beats[i].ch, beats[i].blank, word[i]);
            end
        end
        checks++;
        if (timed_out || rem_at_done !== exp_remaining(4)) begin
            errors++; $display("FAIL full_remaining: got %0d want %0d", rem_at_done, exp_remaining(4));
        end
    endtask

    task automatic test_backpressure();
        mask_op(1'b0, 5'd0, 1'b1);
        mask_op(1'b1, 5'd1, 1'b0);
        mask_op(1'b1, 5'd3, 1'b0);
        run_scan(4, 100, 1, 5, -1);
        checks++;
        if (timed_out || beats.size() != 4 || unstable != 0) begin
            errors++; $display("FAIL stall_seq: beats=%0d unstable=%0d timeout=%0d want 4/0/0",
                beats.size(), unstable, timed_out);
        end
        if (beats.size() == 4) begin
            checks++;
            if ({beats[1].ch, beats[1].pos, beats[1].seen_cycles} !== {5'd31, 5'd2, 32'd6}) begin
                errors++; $display("FAIL stall_beat2: got ch=%0d pos=%0d held=%0d want 31/2/6",
                    beats[1].ch, beats[1].pos, beats[1].seen_cycles);
            end
            checks++;
            if (beats[2].first_seen - beats[1].first_seen != 5 + RD_LAT + 2 || beats[2].pos !== 5'd3) begin
                errors++; $display("FAIL stall_beat3: gap=%0d pos=%0d want %0d/3",
                    beats[2].first_seen - beats[1].first_seen, beats[2].pos, 5 + RD_LAT + 2);
            end
        end
        checks++;
        if (rd_addrs.size() - addr_base != 4) begin
            errors++; $display("FAIL stall_reads: got %0d reads want 4", rd_addrs.size() - addr_base);
        end
    endtask

    task automatic test_len0();
        run_scan(0, 100, -1, 0, -1);
        checks++;
        if (valid_cycles != 0 || rd_addrs.size() != addr_base) begin
            errors++; $display("FAIL len0_quiet: valid=%0d reads=%0d want 0/0", valid_cycles,
                rd_addrs.size() - addr_base);
        end
        checks++;
        if (done_iter != 0 || done_seen != 1 || busy_cycles != 1) begin
            errors++; $display("FAIL len0_done: done_at=%0d pulses=%0d busy=%0d want 0/1/1",
                done_iter, done_seen, busy_cycles);
        end
        checks++;
        if (rem_at_done !== 5'd0) begin
            errors++; $display("FAIL len0_remaining: got %0d want 0", rem_at_done);
        end
    endtask

    task automatic test_reveal_clear();
        for (int p = 1; p <= 3; p++) mem[p] = 5'($urandom_range(30));
        mask_op(1'b1, 5'd1, 1'b0);
        mask_op(1'b1, 5'd3, 1'b0);
        mask_op(1'b1, 5'd2, 1'b1);
        run_scan(3, 100, -1, 0, -1);
        checks++;
        if (timed_out || beats.size() != 3) begin
            errors++; $display("FAIL clrset_count: got %0d beats want 3", beats.size());
        end
        for (int i = 0; i < beats.size() && i < 3; i++) begin
            checks++;
            if ({beats[i].ch, beats[i].blank} !== {(i == 1) ? mem[2] : BLANK, (i != 1)}) begin
                errors++; $display("FAIL clrset_beat%0d: got ch=%0d blank=%0d want ch=%0d blank=%0d",
                    i + 1, beats[i].ch, beats[i].blank, (i == 1) ? mem[2] : BLANK, i != 1);
            end
        end
    endtask

    task automatic test_start_ignored();
        for (int p = 1; p <= 6; p++) mem[p] = 5'($urandom_range(31));
        mask_op(1'b1, 5'd5, 1'b0);
        run_scan(6, 100, -1, 0, 4);
        checks++;
        if (timed_out || beats.size() != 6 || done_seen != 1 || busy_cycles != done_iter + 1) begin
            errors++; $display("FAIL poke_seq: beats=%0d done=%0d busy=%0d done_at=%0d want 6/1/done_at+1",
                beats.size(), done_seen, busy_cycles, done_iter);
        end
        for (int i = 0; i < beats.size() && i < 6; i++) begin
            beat_t e;
            e = model_beat(i + 1, 6);
            checks++;
            if ({beats[i].ch, beats[i].pos, beats[i].blank, beats[i].last} !== {e.ch, e.pos, e.blank, e.last}) begin
                errors++; $display("FAIL poke_beat%0d: got ch=%0d pos=%0d want ch=%0d pos=%0d",
                    i + 1, beats[i].ch, beats[i].pos, e.ch, e.pos);
            end
        end
    endtask

    task automatic test_reset_mid();
        int  done_before;
        bit  seen = 0;
        mask_op(1'b1, 5'd1, 1'b0);
        mask_op(1'b1, 5'd2, 1'b0);
        out_ready = 1'b0;
        start  = 1'b1;
        length = 5'd4;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (out_valid) seen = 1;
            else @(negedge clk);
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rstmid_present: out_valid never rose within 20 cycles"); end
        done_before = done_total;
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({out_valid, busy, done, rden, out_char, out_pos, out_last, out_blank} !== '0) begin
            errors++; $display("FAIL rstmid_async: got %b want all zero",
                {out_valid, busy, done, rden, out_char, out_pos, out_last, out_blank});
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 32; i++) model_mask[i] = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (done_total != done_before || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_nodone: done pulses=%0d busy=%0d want 0/0",
                done_total - done_before, busy);
        end
        run_scan(4, 100, -1, 0, -1);
        checks++;
        if (timed_out || beats.size() != 4 || beats[0].pos !== 5'd1) begin
            errors++; $display("FAIL rstmid_restart: beats=%0d first_pos=%0d want 4/1", beats.size(),
                (beats.size() > 0) ? beats[0].pos : 5'd0);
        end
        for (int i = 0; i < beats.size() && i < 4; i++) begin
            checks++;
            if ({beats[i].ch, beats[i].blank} !== {BLANK, 1'b1}) begin
                errors++; $display("FAIL rstmid_beat%0d: got ch=%0d blank=%0d want 31/1",
                    i + 1, beats[i].ch, beats[i].blank);
            end
        end
    endtask

    task automatic test_random();
        for (int iter = 0; iter < 25; iter++) begin
            int len;
            int bad_addr = 0;
            for (int p = 1; p < 32; p++) mem[p] = 5'($urandom_range(31));
            if ($urandom_range(4) == 0) mask_op(1'b0, 5'd0, 1'b1);
            for (int k = $urandom_range(8); k > 0; k--)
                mask_op(1'b1, 5'($urandom_range(31)), 1'($urandom_range(9) == 0));
            len = ($urandom_range(4) == 0) ? 31 : $urandom_range(31);
            run_scan(len, $urandom_range(100, 40), -1, 0, -1);
            checks++;
            if (timed_out || beats.size() != len || unstable != 0 || done_seen != 1) begin
                errors++; $display("FAIL rand%0d_seq: beats=%0d unstable=%0d done=%0d timeout=%0d want %0d/0/1/0",
                    iter, beats.size(), unstable, done_seen, timed_out, len);
            end
            for (int i = 0; i < beats.size() && i < len; i++) begin
                beat_t e;
                e = model_beat(i + 1, len);
                checks++;
                if ({beats[i].ch, beats[i].pos, beats[i].blank, beats[i].last} !== {e.ch, e.pos, e.blank, e.last}) begin
                    errors++; $display("FAIL rand%0d_beat%0d: got ch=%0d pos=%0d blank=%0d last=%0d want %0d/%0d/%0d/%0d",
                        iter, i + 1, beats[i].ch, beats[i].pos, beats[i].blank, beats[i].last,
                        e.ch, e.pos, e.blank, e.last);
                end
            end
            if (rd_addrs.size() - addr_base != len) bad_addr = 1;
            else for (int i = 0; i < len; i++) if (rd_addrs[addr_base + i] !== 5'(i + 1)) bad_addr = 1;
            checks++;
            if (bad_addr) begin
                errors++; $display("FAIL rand%0d_reads: got %0d reads want addresses 1..%0d in order",
                    iter, rd_addrs.size() - addr_base, len);
            end
            checks++;
            if (rem_at_done !== exp_remaining(len)) begin
                errors++; $display("FAIL rand%0d_remaining: got %0d want %0d", iter, rem_at_done, exp_remaining(len));
            end
        end
    endtask

    initial begin
        start = 1'b0; length = 5'd0; reveal_we = 1'b0; reveal_addr = 5'd0;
        clear_reveal = 1'b0; out_ready = 1'b0; resetn = 1'b0;
        for (int i = 0; i < 32; i++) begin
            mem[i] = 5'd0;
            model_mask[i] = 1'b0;
        end
        test_reset();
        test_basic();
        test_backpressure();
        test_len0();
        test_reveal_clear();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
